// File: rtl/roving_pkg.sv
// Shared types and the pattern-step function for the roving LED generator.
package roving_pkg;

  localparam int MAX_WIDTH = 32;

  localparam logic [1:0] MODE_BOUNCE = 2'd0;
  localparam logic [1:0] MODE_ROTL   = 2'd1;
  localparam logic [1:0] MODE_ROTR   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_STEP, S_WRITE, S_WAIT_W, S_SLEEP, S_WAIT_S, S_CHECK, S_DONE
  } state_t;

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_t;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] c;
    dir_t                 dir;
  } step_t;

  // Next one-hot pattern for a pattern of 'width' live bits; mode 3 behaves as bounce.
  function automatic step_t roving_next(input logic [MAX_WIDTH-1:0] c, input dir_t dir,
                                        input logic [1:0] mode, input int width);
    logic [MAX_WIDTH-1:0] msb;
    logic [MAX_WIDTH-1:0] mask;
    step_t                r;
    msb   = MAX_WIDTH'(1) << (width - 1);
    mask  = (msb << 1) - MAX_WIDTH'(1);
    r.dir = dir;
    case (mode)
      MODE_ROTL: r.c = (c << 1) | (((c & msb) != '0) ? MAX_WIDTH'(1) : '0);
      MODE_ROTR: r.c = (c >> 1) | (c[0] ? msb : '0);
      default: begin
        if (dir == DIR_LEFT && (c & msb) != '0) r.dir = DIR_RIGHT;
        else if (dir == DIR_RIGHT && c[0])      r.dir = DIR_LEFT;
        r.c = (r.dir == DIR_LEFT) ? (c << 1) : (c >> 1);
      end
    endcase
    r.c = r.c & mask;
    return r;
  endfunction

endpackage

// File: rtl/roving_gen.sv
// Roving-LED pattern generator: writes each one-hot frame through write_leds,
// then dwells through sleep, until the frame limit or an abort ends the run.
module roving_gen
  import roving_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MS_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 __clk,
  input  logic                 __reset,
  input  logic                 __start,
  input  logic [1:0]           mode,
  input  logic [MS_WIDTH-1:0]  dwell_ms,
  input  logic [CNT_WIDTH-1:0] frames,
  input  logic                 abort,
  output logic                 __idle,
  output logic                 __valid,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [WIDTH-1:0]     __p_c_write_leds,
  output logic                 __start_write_leds,
  input  logic                 __idle_write_leds,
  input  logic                 __valid_write_leds,
  output logic [MS_WIDTH-1:0]  __p_ms_sleep,
  output logic                 __start_sleep,
  input  logic                 __idle_sleep,
  input  logic                 __valid_sleep
);

  state_t               state, state_n;
  logic [WIDTH-1:0]     c, c_n;
  dir_t                 dir, dir_n;
  logic [1:0]           mode_q, mode_n;
  logic [MS_WIDTH-1:0]  dwell_q, dwell_n;
  logic [CNT_WIDTH-1:0] frames_q, frames_n;
  logic [CNT_WIDTH-1:0] count, count_n;
  logic                 abort_pend, abort_pend_n;
  logic [WIDTH-1:0]     p_c, p_c_n;
  logic                 start_w, start_w_n;
  logic [MS_WIDTH-1:0]  p_ms, p_ms_n;
  logic                 start_s, start_s_n;
  step_t                nxt;

  assign nxt = roving_next(MAX_WIDTH'(c), dir, mode_q, WIDTH);

  if (WIDTH < MAX_WIDTH) begin : g_unused
    logic unused_hi;
    assign unused_hi = |nxt.c[MAX_WIDTH-1:WIDTH];
  end

  // Callee idle flags are informational; the handshake relies on start/valid only.
  logic unused_callee_idle;
  assign unused_callee_idle = __idle_write_leds | __idle_sleep;

  // NOTE: every state register uses <= so all of them update together on the edge.
  always_ff @(posedge __clk or posedge __reset) begin
    if (__reset) begin
      state      <= S_IDLE;
      c          <= WIDTH'(1);
      dir        <= DIR_LEFT;
      mode_q     <= MODE_BOUNCE;
      dwell_q    <= '0;
      frames_q   <= '0;
      count      <= '0;
      abort_pend <= 1'b0;
      p_c        <= '0;
      start_w    <= 1'b0;
      p_ms       <= '0;
      start_s    <= 1'b0;
    end else begin
      state      <= state_n;
      c          <= c_n;
      dir        <= dir_n;
      mode_q     <= mode_n;
      dwell_q    <= dwell_n;
      frames_q   <= frames_n;
      count      <= count_n;
      abort_pend <= abort_pend_n;
      p_c        <= p_c_n;
      start_w    <= start_w_n;
      p_ms       <= p_ms_n;
      start_s    <= start_s_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can form.
  always_comb begin
    state_n      = state;
    c_n          = c;
    dir_n        = dir;
    mode_n       = mode_q;
    dwell_n      = dwell_q;
    frames_n     = frames_q;
    count_n      = count;
    abort_pend_n = abort_pend | ((state != S_IDLE) & abort);
    p_c_n        = p_c;
    start_w_n    = 1'b0;
    p_ms_n       = p_ms;
    start_s_n    = 1'b0;

    case (state)
      S_IDLE: if (__start) state_n = S_LOAD;
      S_LOAD: begin
        c_n          = WIDTH'(1);
        dir_n        = DIR_LEFT;
        count_n      = '0;
        abort_pend_n = abort;
        mode_n       = mode;
        dwell_n      = dwell_ms;
        frames_n     = frames;
        state_n      = S_STEP;
      end
      S_STEP: begin
        // The argument register is loaded with the new pattern so it is valid with the pulse.
        c_n       = nxt.c[WIDTH-1:0];
        dir_n     = nxt.dir;
        p_c_n     = nxt.c[WIDTH-1:0];
        start_w_n = 1'b1;
        state_n   = S_WRITE;
      end
      S_WRITE: state_n = S_WAIT_W;
      S_WAIT_W: begin
        if (__valid_write_leds) begin
          if (dwell_q == '0) begin
            state_n = S_CHECK;
          end else begin
            p_ms_n    = dwell_q;
            start_s_n = 1'b1;
            state_n   = S_SLEEP;
          end
        end
      end
      S_SLEEP:  state_n = S_WAIT_S;
      S_WAIT_S: if (__valid_sleep) state_n = S_CHECK;
      S_CHECK: begin
        count_n = count + 1'b1;
        if (abort_pend || (frames_q != '0 && (count + 1'b1) == frames_q)) state_n = S_DONE;
        else                                                               state_n = S_STEP;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign __idle             = (state == S_IDLE);
  assign __valid            = (state == S_DONE);
  assign frame_count        = count;
  assign __p_c_write_leds   = p_c;
  assign __start_write_leds = start_w;
  assign __p_ms_sleep       = p_ms;
  assign __start_sleep      = start_s;

endmodule

// File: tb/tb_roving_gen.sv
// Directed bench for roving_gen: a WIDTH=4 and a WIDTH=8 instance share behavioural
// write_leds/sleep callees; expected patterns are hand-listed per run.
module tb_roving_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sel8 = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [31:0] dwell = '0;
  logic [15:0] frames = '0;
  logic        valid_w = 1'b0;
  logic        valid_s = 1'b0;
  logic        spur_s = 1'b0;
  bit          w_busy = 1'b0;
  bit          s_busy = 1'b0;
  logic        idle_w, idle_s;

  logic        idle4, vld4, start_w4, start_s4;
  logic [15:0] fc4;
  logic [3:0]  p_c4;
  logic [31:0] p_ms4;
  logic        idle8, vld8, start_w8, start_s8;
  logic [15:0] fc8;
  logic [7:0]  p_c8;
  logic [31:0] p_ms8;

  logic        idle, vld, start_w, start_s;
  logic [15:0] fc;
  logic [7:0]  p_c;
  logic [31:0] p_ms;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          w_n = 0;
  int          s_n = 0;
  int          v_n = 0;
  int          lat_w = 1;
  int          lat_s = 1;
  int          start_edge = 0;
  logic [31:0] dwell_exp = '0;
  logic [7:0]  exp_w[$];
  int          w_times[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign idle_w  = !w_busy;
  assign idle_s  = !s_busy;
  assign idle    = sel8 ? idle8 : idle4;
  assign vld     = sel8 ? vld8 : vld4;
  assign start_w = sel8 ? start_w8 : start_w4;
  assign start_s = sel8 ? start_s8 : start_s4;
  assign fc      = sel8 ? fc8 : fc4;
  assign p_c     = sel8 ? p_c8 : {4'b0, p_c4};
  assign p_ms    = sel8 ? p_ms8 : p_ms4;

  roving_gen #(.WIDTH(4), .MS_WIDTH(32), .CNT_WIDTH(16)) dut4 (
    .__clk(clk), .__reset(rst), .__start(start & ~sel8), .mode(mode), .dwell_ms(dwell),
    .frames(frames), .abort(abort), .__idle(idle4), .__valid(vld4), .frame_count(fc4),
    .__p_c_write_leds(p_c4), .__start_write_leds(start_w4), .__idle_write_leds(idle_w),
    .__valid_write_leds(valid_w), .__p_ms_sleep(p_ms4), .__start_sleep(start_s4),
    .__idle_sleep(idle_s), .__valid_sleep(valid_s)
  );

  roving_gen #(.WIDTH(8), .MS_WIDTH(32), .CNT_WIDTH(16)) dut8 (
    .__clk(clk), .__reset(rst), .__start(start & sel8), .mode(mode), .dwell_ms(dwell),
    .frames(frames), .abort(abort), .__idle(idle8), .__valid(vld8), .frame_count(fc8),
    .__p_c_write_leds(p_c8), .__start_write_leds(start_w8), .__idle_write_leds(idle_w),
    .__valid_write_leds(valid_w), .__p_ms_sleep(p_ms8), .__start_sleep(start_s8),
    .__idle_sleep(idle_s), .__valid_sleep(valid_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // write_leds callee: checks each call against the planned pattern and holds it until valid.
  initial begin : callee_w
    int          cnt;
    logic [7:0]  expv;
    cnt  = 0;
    expv = '0;
    forever begin
      @(posedge clk); #1;
      valid_w = 1'b0;
      if (rst) begin
        w_busy = 1'b0;
      end else if (w_busy) begin
        check("w_arg_hold", p_c, expv);
        check("w_pulse_len", start_w, 0);
        cnt--;
        if (cnt == 0) begin
          valid_w = 1'b1;
          w_busy  = 1'b0;
        end
      end else if (start_w) begin
        w_times.push_back(cyc);
        check("w_call_planned", exp_w.size() > 0, 1);
        expv = (exp_w.size() > 0) ? exp_w.pop_front() : 8'hxx;
        check("w_arg", p_c, expv);
        w_n++;
        w_busy = 1'b1;
        cnt    = lat_w;
      end
    end
  end

  // sleep callee; spur_s drives a stray valid whenever no call is outstanding.
  initial begin : callee_s
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      valid_s = 1'b0;
      if (rst) begin
        s_busy = 1'b0;
      end else if (s_busy) begin
        check("s_arg_hold", p_ms, dwell_exp);
        check("s_pulse_len", start_s, 0);
        cnt--;
        if (cnt == 0) begin
          valid_s = 1'b1;
          s_busy  = 1'b0;
        end
      end else if (start_s) begin
        check("s_arg", p_ms, dwell_exp);
        s_n++;
        s_busy = 1'b1;
        cnt    = lat_s;
      end
      if (!s_busy && spur_s) valid_s = 1'b1;
    end
  end

  initial begin : valid_mon
    forever begin
      @(posedge clk); #1;
      if (vld) v_n++;
    end
  end

  task automatic start_run(input bit w8, input logic [1:0] m, input logic [31:0] d,
                           input logic [15:0] f);
    sel8      = w8;
    mode      = m;
    dwell     = d;
    frames    = f;
    dwell_exp = d;
    w_n = 0; s_n = 0; v_n = 0;
    w_times.delete();
    @(posedge clk); #1;
    start      = 1'b1;
    start_edge = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit hammer);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #1;
      if (vld) seen = 1'b1;
      start = (hammer && !seen) ? ~start : 1'b0;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    @(posedge clk); #1;
    check("valid_one_cycle", vld, 0);
    check("idle_after_done", idle, 1);
  endtask

  task automatic wait_calls(input bit sleep_side, input int n, input int budget);
    int i;
    i = 0;
    while ((sleep_side ? s_n : w_n) < n && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check("calls_reached", sleep_side ? s_n : w_n, n);
  endtask

  task automatic run_summary(input string t, input int wn, input int sn, input int fcount);
    repeat (2) @(posedge clk);
    #1;
    check({t, "_writes"}, w_n, wn);
    check({t, "_sleeps"}, s_n, sn);
    check({t, "_valid_pulses"}, v_n, 1);
    check({t, "_frame_count"}, fc, fcount);
    check({t, "_plan_used"}, exp_w.size(), 0);
    check({t, "_first_write_cycle"}, (w_times.size() > 0) ? w_times[0] : -1, start_edge + 2);
  endtask

  initial begin : main
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle4", idle4, 1);
    check("rst_idle8", idle8, 1);
    check("rst_valid", vld, 0);
    check("rst_start_w", start_w, 0);
    check("rst_start_s", start_s, 0);
    check("rst_p_c", p_c, 0);
    check("rst_p_ms", p_ms, 0);
    check("rst_frame_count", fc, 0);
    @(negedge clk);
    rst = 1'b0;

    // W4 bounce, 8 frames, dwell 5.
    lat_w = 1; lat_s = 1;
    exp_w = '{8'd2, 8'd4, 8'd8, 8'd4, 8'd2, 8'd1, 8'd2, 8'd4};
    start_run(1'b0, 2'd0, 32'd5, 16'd8);
    wait_done(400, 1'b0);
    run_summary("bounce4", 8, 8, 8);
    check("bounce4_period", w_times[1] - w_times[0], 6);
    repeat (3) @(posedge clk);
    #1;
    check("bounce4_count_hold", fc, 8);

    // W8 rotate-left, 9 frames, dwell 0.
    exp_w = '{8'd2, 8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128, 8'd1, 8'd2};
    start_run(1'b1, 2'd1, 32'd0, 16'd9);
    wait_done(400, 1'b0);
    run_summary("rotl8", 9, 0, 9);
    check("rotl8_period_first", w_times[1] - w_times[0], 4);
    check("rotl8_period_wrap", w_times[8] - w_times[7], 4);

    // W8 rotate-right, run forever, abort inside the third sleep wait.
    lat_s = 3;
    exp_w = '{8'd128, 8'd64, 8'd32};
    start_run(1'b1, 2'd2, 32'd7, 16'd0);
    wait_calls(1'b1, 3, 200);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_done(200, 1'b0);
    run_summary("abort8", 3, 3, 3);

    // W8 bounce with start hammered while busy and stray sleep valids.
    lat_s  = 1;
    spur_s = 1'b1;
    exp_w  = '{8'd2, 8'd4, 8'd8, 8'd16};
    start_run(1'b1, 2'd3, 32'd2, 16'd4);
    wait_done(400, 1'b1);
    spur_s = 1'b0;
    run_summary("noise8", 4, 4, 4);
    check("noise8_period", w_times[2] - w_times[1], 6);

    // W4 rotate-left with a 20-cycle write callee.
    lat_w = 20;
    exp_w = '{8'd2, 8'd4};
    start_run(1'b0, 2'd1, 32'd1, 16'd2);
    wait_done(400, 1'b0);
    run_summary("slow4", 2, 2, 2);
    check("slow4_period", w_times[1] - w_times[0], 25);

    // Reset in the middle of a write wait, then a fresh one-frame run.
    exp_w = '{8'd2};
    start_run(1'b0, 2'd0, 32'd3, 16'd0);
    wait_calls(1'b0, 1, 20);
    @(posedge clk); #1;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_idle", idle, 1);
    check("midrst_start_w", start_w, 0);
    check("midrst_start_s", start_s, 0);
    check("midrst_p_c", p_c, 0);
    check("midrst_p_ms", p_ms, 0);
    check("midrst_valid", vld, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_w.delete();
    lat_w = 1;
    exp_w = '{8'd2};
    start_run(1'b0, 2'd0, 32'd0, 16'd1);
    wait_done(100, 1'b0);
    run_summary("after_rst4", 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
